cd_sector_stream_buffer: RTL and testbench
==========================================

Name: cd_sector_stream_buffer

Overview:
Parametrised sector FIFO between the HPS CD image interface and the CDIC.
- Fetches sectors from HPS by LBA, buffers them in single-port block RAM and releases whole sectors on the CDIC sector tick.
- Supersedes runtime sector-size calibration with a fixed SECTOR_WORDS.
- Adds pause/resume without flush, underrun/overflow reporting, a level output and a configurable seek delay and output pacing.

Parameters:
DATA_WIDTH, 16, word width of HPS and CDIC data
ADDR_WIDTH, 15, RAM address bits; depth DEPTH = 2**ADDR_WIDTH words
SECTOR_WORDS, 1188, words per sector (0x930 bytes + 12 subchannel words); 2 <= SECTOR_WORDS <= DEPTH/2
SEEK_SECTORS, 19, sector ticks between seek and first HPS request
PACE_CYCLES, 4, minimum clocks between consecutive out_valid pulses (>=2)
REQ_GAP, 255, idle clocks after ack falls before next request may assert

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
hps_lba  out  32  LBA of requested sector
hps_req  out  1  request; held until hps_ack seen high
hps_ack  in  1  high for duration of one sector transfer
hps_data_valid  in  1  write strobe for hps_data
hps_data  in  DATA_WIDTH  sector word from HPS
seek_lba  in  32  target LBA
seek_valid  in  1  one-cycle pulse: flush, seek, start reading
pause  in  1  level: stop issuing requests, keep contents
sector_tick  in  1  one-cycle CDIC sector strobe (75 Hz)
out_data  out  DATA_WIDTH  word to CDIC, valid with out_valid
out_valid  out  1  one-cycle data strobe
sector_delivered  out  1  one-cycle pulse after last word of a sector
underrun  out  1  one-cycle pulse: tick arrived with no complete sector buffered
overflow  out  1  sticky; set when a write is dropped; cleared by reset or seek
seeking  out  1  high from seek_valid until the first request may issue
level  out  ADDR_WIDTH+1  words currently buffered

Behaviour:
- Reset values: all outputs 0; hps_lba 0; pointers 0; request FSM IDLE; read FSM R_IDLE.
- Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; level = wr_ptr - rd_ptr (modulo 2**(ADDR_WIDTH+1)); full when level == DEPTH.
- RAM port: a write takes priority (addr = wr_ptr[ADDR_WIDTH-1:0] when hps_data_valid). A read is issued only in a cycle with no write, and out_valid follows one cycle later with out_data = RAM[rd_ptr].
- Request FSM:
  - IDLE: seek_valid -> FLUSH.
  - FLUSH: wait until hps_ack == 0 and no read in flight. Then clear pointers, clear overflow, load seek counter = SEEK_SECTORS, go to SEEK_WAIT.
  - SEEK_WAIT: count down one per sector_tick; at 0 -> REQUEST. `seeking` is high in FLUSH and SEEK_WAIT.
  - REQUEST: when !pause, gap counter == 0, and level <= DEPTH - SECTOR_WORDS, assert hps_req. hps_req clears on the cycle hps_ack is sampled high -> TRANSFER.
  - TRANSFER: on falling edge of hps_ack, hps_lba += 1, load gap counter = REQ_GAP, return to REQUEST. The gap counter decrements each clock to 0.
- seek_valid in any state: latch seek_lba into hps_lba, go to FLUSH. If a transfer is active, the remaining words are still written but discarded by the flush, and no LBA increment occurs for it.
- Words per transfer beyond SECTOR_WORDS, or any word written while full, are dropped and set overflow.
- Read FSM:
  - R_IDLE: on sector_tick, if level >= SECTOR_WORDS and request FSM not in FLUSH -> R_STREAM with word count 0; else pulse underrun (only when request FSM is REQUEST/TRANSFER).
  - R_STREAM: issue a read when the pace counter allows (>= PACE_CYCLES clocks since the previous issue) and there is no write this cycle. After SECTOR_WORDS reads, the sector_delivered pulse is issued on the cycle after the final out_valid; then -> R_IDLE.
  - sector_tick while in R_STREAM is ignored.
  - seek_valid aborts R_STREAM after any in-flight read completes; no sector_delivered for the aborted sector.
- Simultaneous write and read-issue: write wins, read slips one cycle; pacing is measured from the actual issue.
- Pointer wrap: natural modulo, no special case.
- Reset mid-transfer: hps_req drops immediately; later hps_data_valid is written but discarded by pointer reset only if it arrives in the reset cycle. Otherwise it counts as normal data in IDLE, where writes are dropped and overflow is not set.

Test Plan:
Params ADDR_WIDTH=6, SECTOR_WORDS=16, SEEK_SECTORS=2, PACE_CYCLES=4, REQ_GAP=3.
1. Seek to LBA 100 -> seeking high for 2 ticks; hps_req with hps_lba=100; after 16-word transfer, next request hps_lba=101 no earlier than 3 clocks after ack falls.
2. Buffer holds 64 words after 4 sectors -> no further request until a sector is consumed; level reads 64, then 48 after delivery; no overflow.
3. Tick with level=16 -> 16 out_valid pulses spaced >=4 clocks, data matches written pattern, sector_delivered one cycle after the 16th; tick with level=10 -> underrun pulse, zero out_valid.
4. pause=1 during steady state -> no new hps_req, contents and level unchanged; pause=0 -> requests resume at next LBA.
5. HPS sends 20 words in one ack -> 16 stored, overflow=1, level=16; then seek -> overflow=0, level=0.
6. seek_valid mid-TRANSFER and mid-R_STREAM -> no LBA increment, no sector_delivered, pointers cleared after ack falls, first new request at the new LBA after 2 ticks.

Source files
------------

// File: rtl/cd_sector_stream_buffer_if.sv
// Signal bundle between the CD sector buffer (slave) and its environment (master):
// the HPS image fetch side, the seek/pause controls and the CDIC delivery side.
interface cd_sector_stream_buffer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 15
) ();
  logic [31:0]           hps_lba;
  logic                  hps_req;
  logic                  hps_ack;
  logic                  hps_data_valid;
  logic [DATA_WIDTH-1:0] hps_data;
  logic [31:0]           seek_lba;
  logic                  seek_valid;
  logic                  pause;
  logic                  sector_tick;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  sector_delivered;
  logic                  underrun;
  logic                  overflow;
  logic                  seeking;
  logic [ADDR_WIDTH:0]   level;

  modport slave (
    input  hps_ack, hps_data_valid, hps_data, seek_lba, seek_valid, pause, sector_tick,
    output hps_lba, hps_req, out_data, out_valid, sector_delivered, underrun, overflow,
           seeking, level
  );

  modport master (
    output hps_ack, hps_data_valid, hps_data, seek_lba, seek_valid, pause, sector_tick,
    input  hps_lba, hps_req, out_data, out_valid, sector_delivered, underrun, overflow,
           seeking, level
  );
endinterface

// File: rtl/cd_sector_stream_buffer.sv
// Sector FIFO between HPS CD image fetch and the CDIC: fetches sectors by LBA into a
// single-port RAM and releases one whole sector per CDIC sector tick, paced.
module cd_sector_stream_buffer #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned SECTOR_WORDS = 1188,
  parameter int unsigned SEEK_SECTORS = 19,
  parameter int unsigned PACE_CYCLES  = 4,
  parameter int unsigned REQ_GAP      = 255
) (
  input logic                    clk,
  input logic                    reset,
  cd_sector_stream_buffer_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned CntW  = $clog2(SECTOR_WORDS + 1);
  localparam int unsigned SeekW = $clog2(SEEK_SECTORS + 2);
  localparam int unsigned GapW  = $clog2(REQ_GAP + 2);
  localparam int unsigned PaceW = $clog2(PACE_CYCLES + 1);

  localparam logic [PW-1:0]    LvlFull   = PW'(DEPTH);
  localparam logic [PW-1:0]    LvlReqMax = PW'(DEPTH - SECTOR_WORDS);
  localparam logic [PW-1:0]    LvlSector = PW'(SECTOR_WORDS);
  localparam logic [CntW-1:0]  SecCnt    = CntW'(SECTOR_WORDS);
  localparam logic [CntW-1:0]  SecLast   = CntW'(SECTOR_WORDS - 1);
  localparam logic [SeekW-1:0] SeekInit  = SeekW'(SEEK_SECTORS);
  localparam logic [GapW-1:0]  GapInit   = GapW'(REQ_GAP);
  localparam logic [PaceW-1:0] PaceMax   = PaceW'(PACE_CYCLES);

  typedef enum logic [2:0] {StIdle, StFlush, StSeekWait, StRequest, StTransfer} req_state_e;
  typedef enum logic {RIdle, RStream} rd_state_e;

  req_state_e            req_state_q, req_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]           hps_lba_q, hps_lba_d;
  logic                  hps_req_q, hps_req_d;
  logic                  ack_q;
  logic [SeekW-1:0]      seek_cnt_q, seek_cnt_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [CntW-1:0]       xfer_cnt_q, xfer_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [PaceW-1:0]      pace_cnt_q, pace_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  out_valid_q, out_valid_d, rd_last_q, rd_last_d;
  logic                  delivered_q, delivered_d, underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  logic [PW-1:0]   level;
  logic [CntW-1:0] xfer_base;
  logic            full, wr_window, enter_xfer, wr_en, wr_drop, flush_done, rd_abort, rd_en;
  logic            seeking;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign full       = (level == LvlFull);
  // Writes land in FLUSH too; the pointer clear at flush exit discards them.
  assign wr_window  = (req_state_q == StFlush) || (req_state_q == StRequest) ||
                      (req_state_q == StTransfer);
  assign enter_xfer = (req_state_q == StRequest) && hps_req_q && bus.hps_ack;
  assign xfer_base  = enter_xfer ? '0 : xfer_cnt_q;
  assign wr_en      = bus.hps_data_valid && wr_window && !full && (xfer_base < SecCnt);
  assign wr_drop    = bus.hps_data_valid && wr_window && !wr_en;
  assign flush_done = (req_state_q == StFlush) && !bus.hps_ack && !out_valid_q &&
                      !bus.seek_valid;
  assign rd_abort   = bus.seek_valid || (req_state_q == StFlush);
  // The RAM port is given to HPS whenever a word is offered; the read slips a cycle.
  assign rd_en      = (rd_state_q == RStream) && !rd_abort && (rd_cnt_q < SecCnt) &&
                      (pace_cnt_q >= PaceMax) && !bus.hps_data_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_state_q <= StIdle;
      rd_state_q  <= RIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hps_lba_q   <= '0;
      hps_req_q   <= 1'b0;
      ack_q       <= 1'b0;
      seek_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      xfer_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      pace_cnt_q  <= PaceMax;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rd_last_q   <= 1'b0;
      delivered_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      req_state_q <= req_state_d;
      rd_state_q  <= rd_state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      hps_lba_q   <= hps_lba_d;
      hps_req_q   <= hps_req_d;
      ack_q       <= bus.hps_ack;
      seek_cnt_q  <= seek_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      pace_cnt_q  <= pace_cnt_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      rd_last_q   <= rd_last_d;
      delivered_q <= delivered_d;
      underrun_q  <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.hps_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else if (rd_en) rdata_q <= ram_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  always_comb begin
    req_state_d = req_state_q;
    hps_lba_d   = hps_lba_q;
    hps_req_d   = hps_req_q;
    seek_cnt_d  = seek_cnt_q;
    gap_cnt_d   = (gap_cnt_q != '0) ? gap_cnt_q - 1'b1 : gap_cnt_q;
    unique case (req_state_q)
      StIdle: ;
      StFlush: begin
        if (flush_done) begin
          req_state_d = StSeekWait;
          seek_cnt_d  = SeekInit;
        end
      end
      StSeekWait: begin
        if (seek_cnt_q == '0) req_state_d = StRequest;
        else if (bus.sector_tick) seek_cnt_d = seek_cnt_q - 1'b1;
      end
      StRequest: begin
        if (enter_xfer) begin
          req_state_d = StTransfer;
          hps_req_d   = 1'b0;
        end else if (!hps_req_q && !bus.pause && (gap_cnt_q == '0) && (level <= LvlReqMax)) begin
          hps_req_d = 1'b1;
        end
      end
      StTransfer: begin
        if (ack_q && !bus.hps_ack) begin
          hps_lba_d   = hps_lba_q + 32'd1;
          gap_cnt_d   = GapInit;
          req_state_d = StRequest;
        end
      end
      default: req_state_d = StIdle;
    endcase
    // A seek overrides everything, including an unfinished transfer's LBA increment.
    if (bus.seek_valid) begin
      req_state_d = StFlush;
      hps_lba_d   = bus.seek_lba;
      hps_req_d   = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q + PW'(rd_en);
    xfer_cnt_d = xfer_base;
    if (bus.hps_data_valid && wr_window && (xfer_base < SecCnt)) xfer_cnt_d = xfer_base + 1'b1;
    overflow_d = overflow_q | wr_drop;
    if (flush_done) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_cnt_d    = rd_cnt_q + CntW'(rd_en);
    underrun_d  = 1'b0;
    delivered_d = 1'b0;
    pace_cnt_d  = rd_en ? PaceW'(1) : ((pace_cnt_q < PaceMax) ? pace_cnt_q + 1'b1 : pace_cnt_q);
    out_valid_d = rd_en;
    rd_last_d   = rd_en && (rd_cnt_q == SecLast);
    unique case (rd_state_q)
      RIdle: begin
        if (bus.sector_tick) begin
          if ((level >= LvlSector) && (req_state_q != StFlush)) begin
            rd_state_d = RStream;
            rd_cnt_d   = '0;
          end else if ((req_state_q == StRequest) || (req_state_q == StTransfer)) begin
            underrun_d = 1'b1;
          end
        end
      end
      RStream: begin
        if (rd_abort) begin
          rd_state_d = RIdle;
        end else if (out_valid_q && rd_last_q) begin
          delivered_d = 1'b1;
          rd_state_d  = RIdle;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    seeking = (req_state_q == StFlush) || (req_state_q == StSeekWait);
  end

  assign bus.hps_lba          = hps_lba_q;
  assign bus.hps_req          = hps_req_q;
  assign bus.out_data         = rdata_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.sector_delivered = delivered_q;
  assign bus.underrun         = underrun_q;
  assign bus.overflow         = overflow_q;
  assign bus.seeking          = seeking;
  assign bus.level            = level;
endmodule

// File: tb/tb_cd_sector_stream_buffer.sv
// Bench for cd_sector_stream_buffer: scripted sector scenarios, a vector table and a
// randomized phase, all checked against a word-queue model of the sector FIFO.
module tb_cd_sector_stream_buffer;
  localparam int unsigned DW = 16, AW = 6, SW = 16, SEEK = 2, PACE = 4, GAP = 3;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cd_sector_stream_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cd_sector_stream_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SECTOR_WORDS(SW), .SEEK_SECTORS(SEEK),
    .PACE_CYCLES(PACE), .REQ_GAP(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0, errors = 0;
  logic [DW-1:0] m_q[$];
  logic [31:0] m_lba = 0;
  bit m_ovf = 0, m_flush = 0;
  int n_out = 0, n_deliv = 0, n_under = 0, stream_words = 0, since_out = 100;
  bit prev_ov = 0;

  typedef struct {
    int words; bit tick; int exp_level; bit exp_ovf; int exp_outs; bit exp_under; bit exp_req;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Output monitor: pacing, data order against the model queue, delivery timing.
  always @(negedge clk) begin
    if (!reset) begin
      since_out++;
      if (bus.sector_delivered) begin
        n_deliv++;
        chk_ok("deliver_timing", prev_ov && stream_words == SW, stream_words, SW);
        stream_words = 0;
      end
      if (bus.out_valid) begin
        n_out++;
        stream_words++;
        chk_ok("pace", since_out >= PACE, since_out, PACE);
        since_out = 0;
        if (!m_flush) begin
          if (m_q.size() == 0) chk_ok("data_avail", 1'b0, 0, 1);
          else chk("out_data", bus.out_data, m_q.pop_front());
        end
      end
      if (bus.underrun) n_under++;
      prev_ov = bus.out_valid;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    bus.sector_tick = 1'b1;
    cyc(1);
    bus.sector_tick = 1'b0;
  endtask

  task automatic seek(input logic [31:0] lba);
    bus.seek_lba   = lba;
    bus.seek_valid = 1'b1;
    m_flush = 1;
    m_q.delete();
    m_lba = lba;
    m_ovf = 0;
    cyc(1);
    bus.seek_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int t = 0;
    while (!bus.hps_req && t < 400) begin
      cyc(1);
      t++;
    end
    ok = bus.hps_req;
    if (!ok) chk_ok("req_timeout", 1'b0, t, 400);
  endtask

  // k is the word index within the current transfer.
  task automatic send_words(input int n, input int k0, input int maxgap);
    logic [DW-1:0] d;
    for (int k = k0; k < k0 + n; k++) begin
      d = DW'($urandom);
      bus.hps_data_valid = 1'b1;
      bus.hps_data = d;
      if (!m_flush) begin
        if (k < SW && m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovf = 1;
      end
      cyc(1);
      bus.hps_data_valid = 1'b0;
      if (maxgap > 0) cyc($urandom_range(0, maxgap));
    end
  endtask

  task automatic start_xfer(output bit ok);
    wait_req(ok);
    if (ok) begin
      chk("hps_lba", bus.hps_lba, m_lba);
      bus.hps_ack = 1'b1;
      cyc(1);
      chk("req_drop_on_ack", bus.hps_req, 0);
    end
  endtask

  task automatic serve(input int n, input int maxgap);
    bit ok;
    start_xfer(ok);
    if (ok) begin
      send_words(n, 0, maxgap);
      bus.hps_ack = 1'b0;
      m_lba++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int t, o0, u0, d0;
    bit ok, under;
    bus.hps_ack = 0; bus.hps_data_valid = 0; bus.hps_data = '0; bus.seek_lba = '0;
    bus.seek_valid = 0; bus.pause = 0; bus.sector_tick = 0;
    tbl = '{
      '{16, 1'b0, 32, 1'b0,  0, 1'b0, 1'b1},
      '{16, 1'b0, 48, 1'b0,  0, 1'b0, 1'b1},
      '{16, 1'b0, 64, 1'b0,  0, 1'b0, 1'b0},
      '{ 0, 1'b1, 48, 1'b0, 16, 1'b0, 1'b1},
      '{ 0, 1'b1, 32, 1'b0, 16, 1'b0, 1'b1},
      '{ 0, 1'b1, 16, 1'b0, 16, 1'b0, 1'b1},
      '{ 0, 1'b1,  0, 1'b0, 16, 1'b0, 1'b1},
      '{ 0, 1'b1,  0, 1'b0,  0, 1'b1, 1'b1},
      '{20, 1'b0, 16, 1'b1,  0, 1'b0, 1'b1},
      '{ 0, 1'b1,  0, 1'b1, 16, 1'b0, 1'b1},
      '{10, 1'b0, 10, 1'b1,  0, 1'b0, 1'b1},
      '{ 0, 1'b1, 10, 1'b1,  0, 1'b1, 1'b1}
    };

    // Reset state
    cyc(3);
    chk("rst_hps_req", bus.hps_req, 0);
    chk("rst_hps_lba", bus.hps_lba, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_seeking", bus.seeking, 0);
    chk("rst_underrun", bus.underrun, 0);
    reset = 1'b0;
    cyc(2);
    tick();
    cyc(3);
    chk("idle_tick_no_underrun", n_under, 0);

    // Seek, seek delay, first request and request gap
    seek(100);
    chk("seeking_after_seek", bus.seeking, 1);
    cyc(3);
    tick();
    cyc(3);
    chk("seeking_after_tick1", bus.seeking, 1);
    chk("no_req_while_seeking", bus.hps_req, 0);
    tick();
    cyc(2);
    chk("seeking_after_tick2", bus.seeking, 0);
    m_flush = 0;
    serve(16, 0);
    t = 0;
    while (!bus.hps_req && t < 50) begin
      cyc(1);
      t++;
    end
    chk_ok("req_gap", bus.hps_req && t >= GAP, t, GAP);
    chk("level_first_sector", bus.level, 16);

    // Vector table: fill, block at full, drain, underrun, per-transfer overflow
    for (int i = 0; i < 12; i++) begin
      o0 = n_out;
      u0 = n_under;
      if (tbl[i].words > 0) serve(tbl[i].words, 0);
      if (tbl[i].tick) begin
        tick();
        cyc(90);
      end else begin
        cyc(8);
      end
      chk($sformatf("tbl%0d_level", i), bus.level, tbl[i].exp_level);
      chk($sformatf("tbl%0d_overflow", i), bus.overflow, tbl[i].exp_ovf);
      chk($sformatf("tbl%0d_outs", i), n_out - o0, tbl[i].exp_outs);
      chk($sformatf("tbl%0d_underrun", i), n_under - u0, tbl[i].exp_under);
      chk($sformatf("tbl%0d_req", i), bus.hps_req, tbl[i].exp_req);
      chk($sformatf("tbl%0d_model_level", i), bus.level, m_q.size());
    end

    // Pause holds off requests without touching contents
    start_xfer(ok);
    bus.pause = 1'b1;
    send_words(6, 0, 0);
    bus.hps_ack = 1'b0;
    m_lba++;
    cyc(30);
    chk("pause_no_req", bus.hps_req, 0);
    chk("pause_level", bus.level, 16);
    bus.pause = 1'b0;
    serve(16, 1);
    cyc(8);
    chk("resume_level", bus.level, 32);

    // Seek while a transfer and a stream are both in progress
    start_xfer(ok);
    send_words(4, 0, 1);
    tick();
    send_words(3, 4, 1);
    cyc(12);
    d0 = n_deliv;
    u0 = n_under;
    seek(500);
    o0 = n_out;
    chk("seek_lba_latched", bus.hps_lba, 500);
    chk("seek_seeking", bus.seeking, 1);
    send_words(9, 7, 0);
    cyc(3);
    chk_ok("no_clear_while_ack", bus.level != 0, int'(bus.level), 1);
    bus.hps_ack = 1'b0;
    cyc(4);
    chk("flush_level", bus.level, 0);
    chk("flush_overflow", bus.overflow, 0);
    chk("flush_no_lba_inc", bus.hps_lba, 500);
    tick();
    cyc(3);
    chk("seek2_seeking", bus.seeking, 1);
    chk("seek2_no_req", bus.hps_req, 0);
    tick();
    cyc(2);
    chk("seek2_done", bus.seeking, 0);
    chk("abort_no_deliver", n_deliv, d0);
    chk_ok("abort_outs", n_out - o0 <= 1, n_out - o0, 1);
    chk("seek_no_underrun", n_under, u0);
    m_flush = 0;
    stream_words = 0;
    serve(16, 2);
    cyc(8);
    chk("post_seek_level", bus.level, 16);

    // Randomized transfers and ticks against the queue model
    for (int i = 0; i < 40; i++) begin
      if (m_q.size() <= DEPTH - SW && $urandom_range(0, 1) == 1) begin
        serve($urandom_range(1, 20), $urandom_range(0, 2));
        cyc(8);
      end else begin
        o0 = n_out;
        u0 = n_under;
        under = m_q.size() < SW;
        tick();
        cyc(90);
        chk("rnd_outs", n_out - o0, under ? 0 : SW);
        chk("rnd_underrun", n_under - u0, under ? 1 : 0);
      end
      chk("rnd_level", bus.level, m_q.size());
      chk("rnd_overflow", bus.overflow, m_ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
